// File: rtl/nn_stage_seq.sv
// Phase sequencer for one neural stage: load -> forward passes -> error -> update.
// Optional watchdog on WAIT/UPD enabled by defining NN_STAGE_SEQ_WATCHDOG_EN.
module nn_stage_seq #(
  parameter int ADDR_W = 6,
  parameter int CNT_W  = 8,
  parameter int WD_CYC = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        load_length,
  input  logic [2:0]        load_depth,
  input  logic [3:0]        error_length,
  input  logic [CNT_W-1:0]  state_length,
  input  logic              st_data_vld,
  input  logic              st_data_fst,
  output logic              st_data_rdy,
  input  logic              expected_vld,
  output logic              expected_rdy,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic              dp_start,
  input  logic              dp_done,
  output logic              err_vld,
  output logic              upd_start,
  input  logic              upd_done,
  output logic              load_finish,
  output logic              fst_err,
  output logic [2:0]        state
`ifdef NN_STAGE_SEQ_WATCHDOG_EN
  ,
  output logic              wd_trip
`endif
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_WAIT = 3'd3,
    S_ERR  = 3'd4,
    S_UPD  = 3'd5,
    S_DONE = 3'd6
  } state_t;

  if (WD_CYC < 1 || ADDR_W < 6 || CNT_W < 1) begin : g_param_check
    $error("nn_stage_seq: invalid parameter values");
  end

  state_t             cur;
  logic [2:0]         ll_q;
  logic [2:0]         ld_q;
  logic [3:0]         el_q;
  logic [CNT_W-1:0]   sl_q;
  logic [2:0]         row;
  logic [2:0]         word;
  logic [CNT_W-1:0]   pass;
  logic [3:0]         ebeat;
  logic               upd_first;
  logic               load_beat;
  logic               cfg_load;
  logic               abort_now;

  assign st_data_rdy  = (cur == S_LOAD);
  assign load_beat    = st_data_vld & st_data_rdy;
  assign mem_wr_en    = load_beat;
  assign mem_wr_addr  = ADDR_W'(row) * (ADDR_W'(ld_q) + ADDR_W'(1)) + ADDR_W'(word);
  assign expected_rdy = (cur == S_ERR);
  assign err_vld      = expected_vld & expected_rdy;
  assign dp_start     = (cur == S_RUN);
  assign upd_start    = upd_first;
  assign load_finish  = (cur == S_DONE) & ~abort_now;
  assign state        = cur;

`ifdef NN_STAGE_SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(WD_CYC + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            wd_abort;
  logic            wd_run;
  logic            wd_hit;

  // Counter only advances while a wait state is not being satisfied this cycle.
  assign wd_run    = ((cur == S_WAIT) && !dp_done) || ((cur == S_UPD) && !upd_done);
  assign wd_hit    = wd_run && (wd_cnt == WD_W'(WD_CYC - 1));
  assign abort_now = wd_abort;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt   <= '0;
      wd_abort <= 1'b0;
      wd_trip  <= 1'b0;
    end else begin
      if (wd_hit) begin
        wd_cnt   <= '0;
        wd_abort <= 1'b1;
        wd_trip  <= 1'b1;
      end else if (wd_run) begin
        wd_cnt <= wd_cnt + WD_W'(1);
      end else begin
        wd_cnt <= '0;
      end
      if (cur == S_DONE) wd_abort <= 1'b0;
    end
  end
`else
  assign abort_now = 1'b0;
`endif

  // Config is captured only when a new load begins, from IDLE or straight from DONE.
  assign cfg_load = start && ((cur == S_IDLE) || ((cur == S_DONE) && !abort_now));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ll_q <= '0;
      ld_q <= '0;
      el_q <= '0;
      sl_q <= '0;
    end else if (cfg_load) begin
      ll_q <= load_length;
      ld_q <= load_depth;
      el_q <= error_length;
      sl_q <= state_length;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur       <= S_IDLE;
      row       <= '0;
      word      <= '0;
      pass      <= '0;
      ebeat     <= '0;
      upd_first <= 1'b0;
      fst_err   <= 1'b0;
    end else begin
      upd_first <= 1'b0;
      case (cur)
        S_IDLE: if (start) cur <= S_LOAD;
        S_LOAD: begin
          if (load_beat) begin
            if (st_data_fst && ((row != 3'd0) || (word != 3'd0))) fst_err <= 1'b1;
            if (word == ld_q) begin
              word <= '0;
              if (row == ll_q) begin
                row <= '0;
                cur <= S_RUN;
              end else begin
                row <= row + 3'd1;
              end
            end else begin
              word <= word + 3'd1;
            end
          end
        end
        S_RUN: cur <= S_WAIT;
        S_WAIT: begin
          if (dp_done) begin
            if (pass == sl_q) begin
              pass <= '0;
              cur  <= S_ERR;
            end else begin
              pass <= pass + 1'b1;
              cur  <= S_RUN;
            end
          end
        end
        S_ERR: begin
          if (err_vld) begin
            if (ebeat == el_q) begin
              ebeat     <= '0;
              cur       <= S_UPD;
              upd_first <= 1'b1;
            end else begin
              ebeat <= ebeat + 4'd1;
            end
          end
        end
        S_UPD: if (upd_done) cur <= S_DONE;
        S_DONE: cur <= (start && !abort_now) ? S_LOAD : S_IDLE;
        default: cur <= S_IDLE;
      endcase
`ifdef NN_STAGE_SEQ_WATCHDOG_EN
      if (wd_hit) begin
        cur       <= S_DONE;
        pass      <= '0;
        upd_first <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_nn_stage_seq.sv
// Scoreboard bench for nn_stage_seq: queued expected addresses/beats checked as the DUT emits them.
// Watchdog scenario runs only when NN_STAGE_SEQ_WATCHDOG_EN is defined.
module tb_nn_stage_seq;
  localparam int ADDR_W = 6;
  localparam int CNT_W  = 8;
  localparam int WD_CYC = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [2:0]        load_length = '0;
  logic [2:0]        load_depth = '0;
  logic [3:0]        error_length = '0;
  logic [CNT_W-1:0]  state_length = '0;
  logic              st_data_vld = 1'b0;
  logic              st_data_fst = 1'b0;
  logic              expected_vld = 1'b0;
  logic              dp_done = 1'b0;
  logic              upd_done = 1'b0;
  logic              st_data_rdy;
  logic              expected_rdy;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic              dp_start;
  logic              err_vld;
  logic              upd_start;
  logic              load_finish;
  logic              fst_err;
  logic [2:0]        state;
`ifdef NN_STAGE_SEQ_WATCHDOG_EN
  logic              wd_trip;
`endif

  int   total = 0;
  int   bad = 0;
  int   addr_q[$];
  int   err_q[$];
  logic exp_fst_err = 1'b0;

  nn_stage_seq #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .WD_CYC(WD_CYC)) dut (
    .clk(clk), .reset(reset), .start(start),
    .load_length(load_length), .load_depth(load_depth),
    .error_length(error_length), .state_length(state_length),
    .st_data_vld(st_data_vld), .st_data_fst(st_data_fst), .st_data_rdy(st_data_rdy),
    .expected_vld(expected_vld), .expected_rdy(expected_rdy),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
    .dp_start(dp_start), .dp_done(dp_done), .err_vld(err_vld),
    .upd_start(upd_start), .upd_done(upd_done),
    .load_finish(load_finish), .fst_err(fst_err), .state(state)
`ifdef NN_STAGE_SEQ_WATCHDOG_EN
    , .wd_trip(wd_trip)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b0;
    start = 1'b0;
    st_data_vld = 1'b0;
    st_data_fst = 1'b0;
    expected_vld = 1'b0;
    dp_done = 1'b0;
    upd_done = 1'b0;
    addr_q.delete();
    err_q.delete();
    exp_fst_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Drives n load beats (mode 0: always valid, mode 1: valid pattern 1,0,0,1).
  task automatic load_phase(input int n, input int mode, input int fst_at);
    int   pushed;
    int   cyc;
    int   exp_addr;
    logic vld;
    logic fst;
    pushed = 0;
    cyc = 0;
    while (pushed < n && cyc < 400) begin
      vld = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      fst = vld && (pushed == fst_at);
      st_data_vld = vld;
      st_data_fst = fst;
      if (vld) begin
        addr_q.push_back(pushed);
        pushed++;
      end
      @(negedge clk);
      total++;
      if (st_data_rdy !== 1'b1) begin
        bad++;
        $display("[TB] FAIL load_rdy: got %b want 1", st_data_rdy);
      end
      total++;
      if (mem_wr_en !== vld) begin
        bad++;
        $display("[TB] FAIL load_wr_en: got %b want %b (cycle %0d)", mem_wr_en, vld, cyc);
      end
      total++;
      if (fst_err !== exp_fst_err) begin
        bad++;
        $display("[TB] FAIL fst_err: got %b want %b", fst_err, exp_fst_err);
      end
      total++;
      if ({dp_start, expected_rdy, upd_start, load_finish} !== 4'b0000) begin
        bad++;
        $display("[TB] FAIL load_quiet: got %b want 0000",
                 {dp_start, expected_rdy, upd_start, load_finish});
      end
      if (mem_wr_en === 1'b1) begin
        total++;
        if (addr_q.size() == 0) begin
          bad++;
          $display("[TB] FAIL load_addr: got write at %0d want none", mem_wr_addr);
        end else begin
          exp_addr = addr_q.pop_front();
          if (mem_wr_addr !== ADDR_W'(exp_addr)) begin
            bad++;
            $display("[TB] FAIL load_addr: got %0d want %0d", mem_wr_addr, exp_addr);
          end
        end
      end
      tick();
      if (fst && (pushed - 1) > 0) exp_fst_err = 1'b1;
      cyc++;
    end
    st_data_vld = 1'b0;
    st_data_fst = 1'b0;
    total++;
    if (addr_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL load_drain: got %0d unwritten beats want 0", addr_q.size());
      addr_q.delete();
    end
  endtask

  task automatic run_phases(input int npass);
    for (int p = 0; p < npass; p++) begin
      @(negedge clk);
      total++;
      if ({state, dp_start, expected_rdy} !== {3'd2, 1'b1, 1'b0}) begin
        bad++;
        $display("[TB] FAIL run_start: got state=%0d dp_start=%b exp_rdy=%b want 2/1/0",
                 state, dp_start, expected_rdy);
      end
      tick();
      @(negedge clk);
      total++;
      if ({state, dp_start, expected_rdy} !== {3'd3, 1'b0, 1'b0}) begin
        bad++;
        $display("[TB] FAIL run_wait: got state=%0d dp_start=%b exp_rdy=%b want 3/0/0",
                 state, dp_start, expected_rdy);
      end
      tick();
      dp_done = 1'b1;
      @(negedge clk);
      total++;
      if ({state, expected_rdy} !== {3'd3, 1'b0}) begin
        bad++;
        $display("[TB] FAIL run_done: got state=%0d exp_rdy=%b want 3/0", state, expected_rdy);
      end
      tick();
      dp_done = 1'b0;
    end
  endtask

  // Accepts error beats; stop_after >= 0 leaves the phase early (mid-ERR).
  task automatic err_phase(input int n, input int mode, input int stop_after);
    int   pushed;
    int   cyc;
    int   dummy;
    logic vld;
    pushed = 0;
    cyc = 0;
    while (pushed < n && cyc < 200 && !(stop_after >= 0 && pushed >= stop_after)) begin
      vld = (mode == 0) ? 1'b1 : (cyc % 2 == 0);
      expected_vld = vld;
      if (vld) begin
        err_q.push_back(pushed);
        pushed++;
      end
      @(negedge clk);
      total++;
      if ({state, expected_rdy, err_vld} !== {3'd4, 1'b1, vld}) begin
        bad++;
        $display("[TB] FAIL err_beat: got state=%0d rdy=%b err_vld=%b want 4/1/%b",
                 state, expected_rdy, err_vld, vld);
      end
      if (err_vld === 1'b1 && err_q.size() != 0) dummy = err_q.pop_front();
      tick();
      cyc++;
    end
    expected_vld = 1'b0;
    total++;
    if (err_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL err_drain: got %0d unaccepted beats want 0", err_q.size());
      err_q.delete();
    end
  endtask

  task automatic upd_phase(input int delay);
    if (delay == 0) upd_done = 1'b1;
    @(negedge clk);
    total++;
    if ({state, upd_start} !== {3'd5, 1'b1}) begin
      bad++;
      $display("[TB] FAIL upd_entry: got state=%0d upd_start=%b want 5/1", state, upd_start);
    end
    tick();
    upd_done = 1'b0;
    for (int i = 0; i < delay; i++) begin
      if (i == delay - 1) upd_done = 1'b1;
      @(negedge clk);
      total++;
      if ({state, upd_start, load_finish} !== {3'd5, 1'b0, 1'b0}) begin
        bad++;
        $display("[TB] FAIL upd_wait: got state=%0d upd_start=%b lf=%b want 5/0/0",
                 state, upd_start, load_finish);
      end
      tick();
      upd_done = 1'b0;
    end
    @(negedge clk);
    total++;
    if ({state, load_finish} !== {3'd6, 1'b1}) begin
      bad++;
      $display("[TB] FAIL done_pulse: got state=%0d load_finish=%b want 6/1", state, load_finish);
    end
    tick();
  endtask

  task automatic test_reset;
    #2;
    reset = 1'b0;
    start = 1'b1;
    @(negedge clk);
    total++;
    if (state !== 3'd0) begin
      bad++;
      $display("[TB] FAIL reset_state: got %0d want 0", state);
    end
    total++;
    if ({st_data_rdy, mem_wr_en, dp_start, err_vld, expected_rdy, upd_start, load_finish, fst_err}
        !== 8'h00) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got %b want 00000000",
               {st_data_rdy, mem_wr_en, dp_start, err_vld, expected_rdy, upd_start, load_finish, fst_err});
    end
    total++;
    if (mem_wr_addr !== '0) begin
      bad++;
      $display("[TB] FAIL reset_addr: got %0d want 0", mem_wr_addr);
    end
    tick();
    start = 1'b0;
    reset = 1'b1;
    tick();
    @(negedge clk);
    total++;
    if (state !== 3'd0) begin
      bad++;
      $display("[TB] FAIL idle_hold: got %0d want 0", state);
    end
    tick();
  endtask

  task automatic test_full_cycle;
    load_length = 3'd5;
    load_depth = 3'd5;
    state_length = '0;
    error_length = 4'd11;
    start = 1'b1;
    tick();
    load_phase(36, 0, -1);
    run_phases(1);
    err_phase(12, 0, -1);
    upd_phase(2);
    load_phase(3, 0, -1);
    do_reset();
  endtask

  task automatic test_multi_pass;
    load_length = 3'd1;
    load_depth = 3'd1;
    state_length = 8'd2;
    error_length = 4'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    load_length = 3'd7;
    load_depth = 3'd7;
    state_length = 8'd0;
    error_length = 4'd15;
    load_phase(4, 0, -1);
    run_phases(3);
    err_phase(2, 1, -1);
    upd_phase(0);
    @(negedge clk);
    total++;
    if ({state, load_finish} !== {3'd0, 1'b0}) begin
      bad++;
      $display("[TB] FAIL back_to_idle: got state=%0d lf=%b want 0/0", state, load_finish);
    end
    tick();
  endtask

  task automatic test_stall;
    load_length = 3'd2;
    load_depth = 3'd2;
    state_length = '0;
    error_length = 4'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    load_phase(9, 1, 0);
    @(negedge clk);
    total++;
    if ({state, dp_start} !== {3'd2, 1'b1}) begin
      bad++;
      $display("[TB] FAIL stall_run: got state=%0d dp_start=%b want 2/1", state, dp_start);
    end
    tick();
    do_reset();
  endtask

  task automatic test_fst_err;
    load_length = 3'd2;
    load_depth = 3'd2;
    state_length = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    load_phase(9, 0, 7);
    run_phases(1);
    @(negedge clk);
    total++;
    if (fst_err !== 1'b1) begin
      bad++;
      $display("[TB] FAIL fst_sticky: got %b want 1", fst_err);
    end
    tick();
    do_reset();
  endtask

  task automatic test_reset_mid_err;
    load_length = 3'd5;
    load_depth = 3'd5;
    state_length = '0;
    error_length = 4'd11;
    start = 1'b1;
    tick();
    start = 1'b0;
    load_phase(36, 0, -1);
    run_phases(1);
    err_phase(12, 0, 5);
    reset = 1'b0;
    #1;
    total++;
    if ({state, expected_rdy, err_vld, upd_start, load_finish, dp_start, mem_wr_en}
        !== {3'd0, 6'b000000}) begin
      bad++;
      $display("[TB] FAIL midreset_async: got state=%0d ctl=%b want 0/000000",
               state, {expected_rdy, err_vld, upd_start, load_finish, dp_start, mem_wr_en});
    end
    @(negedge clk);
    total++;
    if ({state, fst_err, mem_wr_addr} !== {3'd0, 1'b0, 6'd0}) begin
      bad++;
      $display("[TB] FAIL midreset_hold: got state=%0d fst=%b addr=%0d want 0/0/0",
               state, fst_err, mem_wr_addr);
    end
    tick();
    reset = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    load_phase(3, 0, -1);
    do_reset();
  endtask

`ifdef NN_STAGE_SEQ_WATCHDOG_EN
  task automatic test_watchdog;
    load_length = 3'd0;
    load_depth = 3'd0;
    state_length = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    load_phase(1, 0, -1);
    @(negedge clk);
    total++;
    if (state !== 3'd2) begin
      bad++;
      $display("[TB] FAIL wd_run: got %0d want 2", state);
    end
    tick();
    for (int i = 0; i < WD_CYC; i++) begin
      @(negedge clk);
      total++;
      if ({wd_trip, state, load_finish} !== {1'b0, 3'd3, 1'b0}) begin
        bad++;
        $display("[TB] FAIL wd_wait: got trip=%b state=%0d lf=%b want 0/3/0 (cycle %0d)",
                 wd_trip, state, load_finish, i);
      end
      tick();
    end
    @(negedge clk);
    total++;
    if ({wd_trip, state, load_finish} !== {1'b1, 3'd6, 1'b0}) begin
      bad++;
      $display("[TB] FAIL wd_trip: got trip=%b state=%0d lf=%b want 1/6/0",
               wd_trip, state, load_finish);
    end
    tick();
    @(negedge clk);
    total++;
    if ({wd_trip, state, load_finish} !== {1'b1, 3'd0, 1'b0}) begin
      bad++;
      $display("[TB] FAIL wd_idle: got trip=%b state=%0d lf=%b want 1/0/0",
               wd_trip, state, load_finish);
    end
    tick();
    do_reset();
  endtask
`endif

  initial begin
    test_reset();
    test_full_cycle();
    test_multi_pass();
    test_stall();
    test_fst_err();
    test_reset_mid_err();
`ifdef NN_STAGE_SEQ_WATCHDOG_EN
    test_watchdog();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
